alu_seq: RTL and testbench

Parametrised, handshaked successor to the 1-bit ALU slice. Builds a WIDTH-bit ALU from a combinational core, registers its result behind valid/ready handshakes and adds a multi-cycle unsigned shift-add multiply (MULTU). Sits between the decode/operand stage and writeback of the datapath, so the pipeline can stall on either side.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_core.sv | 62 ++++++
 rtl/alu_seq.sv | 156 +++++++++++++++
 tb/tb_alu_seq.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: MIPS funct op codes, the
// controller state encoding and a helper that flags supported op codes.
package alu_pkg;

    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_XOR   = 6'd38;
    localparam logic [5:0] OP_NOR   = 6'd39;
    localparam logic [5:0] OP_SLT   = 6'd42;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    function automatic logic supported_op(input logic [5:0] sel);
        logic ok;
        case (sel)
            OP_MULTU, OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR, OP_NOR, OP_SLT: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU.
//   in_valid/in_ready : request handshake carrying a, b, sel
//   out_valid/out_ready : result handshake carrying result, result_hi and flags
// master = decode/writeback side, slave = the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [5:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             c_out;
    logic             overflow;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, result, result_hi, c_out, overflow, zero, illegal
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, result, result_hi, c_out, overflow, zero, illegal
    );
endinterface

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU core built as a ripple of per-bit slices.
//   a, b     : operands
//   sel      : MIPS funct op code
//   result   : logic/arith result; SLT puts its set bit in bit 0
//   c_out    : MSB carry for ADD/SUB (SUB: 1 = no borrow), else 0
//   overflow : signed overflow for ADD/SUB, else 0
//   illegal  : sel is not a supported code (result is then 0)
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [5:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             illegal
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             set_bit;

    always_comb begin
        // SLT rides on the subtract path
        is_sub = (sel == OP_SUB) || (sel == OP_SLT);
        b_eff  = is_sub ? ~b : b;
        sum    = '0;
        carry  = is_sub;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b_eff[i] ^ carry;
            carry  = (a[i] & b_eff[i]) | (carry & (a[i] ^ b_eff[i]));
        end
        ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        // sign of the difference corrected by overflow gives a true signed compare
        set_bit = sum[WIDTH-1] ^ ovf;

        result   = '0;
        c_out    = 1'b0;
        overflow = 1'b0;
        case (sel)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            OP_ADD, OP_SUB: begin
                result   = sum;
                c_out    = carry;
                overflow = ovf;
            end
            OP_SLT: result[0] = set_bit;
            default: result = '0;
        endcase
        illegal = !supported_op(sel);
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered results and a multi-cycle
// unsigned shift-add multiply.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of alu_seq_if (request in, registered result out)
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               c_out_q, c_out_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;

    logic               in_ready;
    logic               accept;
    logic [WIDTH-1:0]   core_result;
    logic               core_c_out;
    logic               core_ovf;
    logic               core_illegal;
    logic [WIDTH:0]     addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (bus.a),
        .b        (bus.b),
        .sel      (bus.sel),
        .result   (core_result),
        .c_out    (core_c_out),
        .overflow (core_ovf),
        .illegal  (core_illegal)
    );

    always_comb begin
        in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
        accept   = bus.in_valid && in_ready;

        // carry of the high-half add is kept and shifted down with the accumulator
        addend   = mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}};
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + addend;
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        c_out_d     = c_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.sel == OP_MULTU) begin
                        mcand_d  = bus.a;
                        mplier_d = bus.b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        result_d    = core_result;
                        result_hi_d = '0;
                        c_out_d     = core_c_out;
                        overflow_d  = core_ovf;
                        illegal_d   = core_illegal;
                        // an illegal op reports only the illegal flag
                        zero_d      = !core_illegal && (core_result == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = mul_next;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    result_d    = mul_next[WIDTH-1:0];
                    result_hi_d = mul_next[2*WIDTH-1:WIDTH];
                    c_out_d     = 1'b0;
                    overflow_d  = 1'b0;
                    illegal_d   = 1'b0;
                    zero_d      = (mul_next[WIDTH-1:0] == '0);
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            c_out_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            c_out_q     <= c_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        c;
        logic        ov;
        logic        z;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural definition
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sel);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      sr;
        logic [32:0] s;
        logic [63:0] p;
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (sel)
            OP_AND: e.lo = a & b;
            OP_OR:  e.lo = a | b;
            OP_XOR: e.lo = a ^ b;
            OP_NOR: e.lo = ~(a | b);
            OP_ADD: begin
                s    = {1'b0, a} + {1'b0, b};
                e.lo = s[31:0];
                e.c  = s[32];
                sr   = sa + sb;
                e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            OP_SUB: begin
                e.lo = a - b;
                e.c  = (a >= b);
                sr   = sa - sb;
                e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            OP_SLT: e.lo = (sa < sb) ? 32'd1 : 32'd0;
            OP_MULTU: begin
                p    = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                e.ill = 1'b1;
                return e;
            end
        endcase
        e.z = (e.lo == 32'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every cycle a result is presented it must match the head of the scoreboard
    initial begin
        exp_t got;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out_valid: got result %0h with no request pending (t=%0t)",
                             bus.result, $time);
                end else begin
                    got = {bus.result_hi, bus.result, bus.c_out, bus.overflow, bus.zero, bus.illegal};
                    check("scoreboard", 128'(got), 128'(sb_q[0]));
                    if (bus.out_ready) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 9) < 7);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sel,
                        input bit track, output int waited);
        int t;
        bus.a        = a;
        bus.b        = b;
        bus.sel      = sel;
        bus.in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.in_ready && t < 300);
        waited = t;
        if (!bus.in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, expected acceptance", t);
        end else if (track) begin
            sb_q.push_back(model(a, b, sel));
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge (inclusive) to the first out_valid; leaves time at that negedge.
    task automatic measure(input string name, input int exp_edges, input bit chk_busy);
        int edges;
        edges = 1;
        while (1) begin
            @(negedge clk);
            if (bus.out_valid || edges > 100) break;
            if (chk_busy) check("in_ready_busy", 128'(bus.in_ready), 128'(0));
            edges++;
        end
        check(name, 128'(edges), 128'(exp_edges));
    endtask

    initial begin
        int          waited;
        int          budget;
        bit          seen;
        logic [5:0]  ops[7];
        logic [5:0]  sel;
        logic [31:0] ra;
        logic [31:0] rb;
        ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD, OP_SUB, OP_SLT};

        // reset with a request pending
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 32'd3;
        bus.b         = 32'd4;
        bus.sel       = OP_ADD;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs",
                  128'({bus.out_valid, bus.result, bus.result_hi, bus.c_out, bus.overflow, bus.zero, bus.illegal}),
                  128'(0));
        end
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", 128'(bus.in_ready), 128'(1));
        check("out_valid_after_reset", 128'(bus.out_valid), 128'(0));
        @(posedge clk);
        #1;

        // ADD overflow
        send(32'h7FFF_FFFF, 32'd1, OP_ADD, 1'b1, waited);
        measure("lat_add", 1, 1'b0);
        check("add_result", 128'(bus.result), 128'(32'h8000_0000));
        check("add_overflow", 128'(bus.overflow), 128'(1));
        check("add_c_out", 128'(bus.c_out), 128'(0));
        @(posedge clk);
        #1;

        // SUB equal operands
        send(32'd5, 32'd5, OP_SUB, 1'b1, waited);
        measure("lat_sub", 1, 1'b0);
        check("sub_result", 128'(bus.result), 128'(0));
        check("sub_zero", 128'(bus.zero), 128'(1));
        check("sub_c_out", 128'(bus.c_out), 128'(1));
        @(posedge clk);
        #1;

        // SLT where the subtraction overflows
        send(32'h8000_0000, 32'd1, OP_SLT, 1'b1, waited);
        measure("lat_slt", 1, 1'b0);
        check("slt_result", 128'(bus.result), 128'(1));
        @(posedge clk);
        #1;

        // MULTU max*max
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULTU, 1'b1, waited);
        measure("lat_multu", 33, 1'b1);
        check("multu_hi", 128'(bus.result_hi), 128'(32'hFFFF_FFFE));
        check("multu_lo", 128'(bus.result), 128'(32'h0000_0001));
        @(posedge clk);
        #1;

        // MULTU with zero operand still takes the full iteration count
        send(32'd0, 32'h1234_5678, OP_MULTU, 1'b1, waited);
        measure("lat_multu_zero", 33, 1'b1);
        check("multu_zero_flag", 128'(bus.zero), 128'(1));
        @(posedge clk);
        #1;

        // back-pressure: AND held while OR waits
        bus.out_ready = 1'b0;
        send(32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 1'b1, waited);
        bus.a        = 32'h0000_00FF;
        bus.b        = 32'h0F00_0000;
        bus.sel      = OP_OR;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 128'(bus.in_ready), 128'(0));
            check("bp_out_valid", 128'(bus.out_valid), 128'(1));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(32'h0000_00FF, 32'h0F00_0000, OP_OR, 1'b1, waited);
        check("bp_same_edge_accept", 128'(waited), 128'(1));
        measure("lat_or", 1, 1'b0);
        @(posedge clk);
        #1;

        // unsupported op code
        send(32'd123, 32'd456, 6'd0, 1'b1, waited);
        measure("lat_illegal", 1, 1'b0);
        check("illegal_flag", 128'(bus.illegal), 128'(1));
        check("illegal_result", 128'(bus.result), 128'(0));
        @(posedge clk);
        #1;

        // reset in the middle of a multiply
        send(32'hDEAD_BEEF, 32'h0000_1234, OP_MULTU, 1'b0, waited);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort_no_out_valid", 128'(seen), 128'(0));
        check("abort_in_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;

        // randomized traffic with random back-pressure
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            case ($urandom_range(0, 9))
                7:       sel = OP_MULTU;
                8, 9:    sel = 6'($urandom_range(0, 63));
                default: sel = ops[$urandom_range(0, 6)];
            endcase
            ra = rand_operand();
            rb = rand_operand();
            send(ra, rb, sel, 1'b1, waited);
        end

        budget = 0;
        while (sb_q.size() != 0 && budget < 1000) begin
            @(posedge clk);
            budget++;
        end
        #1;
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        budget = 0;
        while (sb_q.size() != 0 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        check("scoreboard_drained", 128'(sb_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
